// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : elevator_scheduler
// Description : Four-floor SCAN elevator controller with latched calls,
//               per-floor travel timer and re-triggerable door timer.
// Revision    : 1.0 - initial release
// ============================================================================
module elevator_scheduler #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] call,
    output logic [1:0] position,
    output logic       moving,
    output logic       dir_up,
    output logic       door_open,
    output logic [3:0] pending
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MOVING = 2'd1,
        ST_DOOR   = 2'd2
    } state_t;

    localparam logic [7:0] C_TRAVEL_LOAD = 8'(TRAVEL_CYCLES - 1);
    localparam logic [7:0] C_DOOR_LOAD   = 8'(DOOR_CYCLES - 1);

    state_t     r_state, w_state_nxt;
    logic [1:0] r_pos, w_pos_nxt, w_step_pos, w_eval_pos;
    logic       r_dir_up, w_dir_nxt;
    logic [7:0] r_travel, w_travel_nxt, r_door, w_door_nxt;
    logic [3:0] r_pending, w_pending_nxt, w_req;
    logic       w_above, w_below, w_ahead, w_behind;

    function automatic logic any_above(input logic [3:0] r, input logic [1:0] f);
        logic a;
        a = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i > int'(f)) a = a | r[i];
        return a;
    endfunction

    function automatic logic any_below(input logic [3:0] r, input logic [1:0] f);
        logic b;
        b = 1'b0;
        for (int i = 0; i < 4; i++)
            if (i < int'(f)) b = b | r[i];
        return b;
    endfunction

    assign w_req      = r_pending | call;
    assign w_step_pos = r_dir_up ? r_pos + 2'd1 : r_pos - 2'd1;
    // When the car completes a floor move, decisions are made at the new floor.
    assign w_eval_pos = (r_state == ST_MOVING && r_travel == 8'd0) ? w_step_pos : r_pos;
    assign w_above    = any_above(w_req, w_eval_pos);
    assign w_below    = any_below(w_req, w_eval_pos);
    assign w_ahead    = r_dir_up ? w_above : w_below;
    assign w_behind   = r_dir_up ? w_below : w_above;

    always_comb begin
        w_state_nxt  = r_state;
        w_pos_nxt    = r_pos;
        w_dir_nxt    = r_dir_up;
        w_travel_nxt = r_travel;
        w_door_nxt   = r_door;
        case (r_state)
            ST_IDLE: begin
                if (w_req[r_pos]) begin
                    w_state_nxt = ST_DOOR;
                    w_door_nxt  = C_DOOR_LOAD;
                end else if (|w_req) begin
                    w_state_nxt  = ST_MOVING;
                    w_travel_nxt = C_TRAVEL_LOAD;
                    if (!w_ahead) w_dir_nxt = ~r_dir_up;
                end
            end
            ST_MOVING: begin
                if (r_travel != 8'd0) begin
                    w_travel_nxt = r_travel - 8'd1;
                end else begin
                    w_pos_nxt = w_step_pos;
                    if (w_req[w_step_pos]) begin
                        w_state_nxt = ST_DOOR;
                        w_door_nxt  = C_DOOR_LOAD;
                    end else if (w_ahead) begin
                        w_travel_nxt = C_TRAVEL_LOAD;
                    end else if (w_behind) begin
                        w_dir_nxt    = ~r_dir_up;
                        w_travel_nxt = C_TRAVEL_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DOOR: begin
                if (call[r_pos]) begin
                    w_door_nxt = C_DOOR_LOAD;
                end else if (r_door != 8'd0) begin
                    w_door_nxt = r_door - 8'd1;
                end else begin
                    w_travel_nxt = C_TRAVEL_LOAD;
                    if (w_ahead) begin
                        w_state_nxt = ST_MOVING;
                    end else if (w_behind) begin
                        w_state_nxt = ST_MOVING;
                        w_dir_nxt   = ~r_dir_up;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A floor being served (door open there after this edge) never latches.
        for (int i = 0; i < 4; i++)
            w_pending_nxt[i] = w_req[i] & ~(w_state_nxt == ST_DOOR && w_pos_nxt == 2'(i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pos     <= 2'd0;
            r_dir_up  <= 1'b1;
            r_travel  <= 8'd0;
            r_door    <= 8'd0;
            r_pending <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pos     <= w_pos_nxt;
            r_dir_up  <= w_dir_nxt;
            r_travel  <= w_travel_nxt;
            r_door    <= w_door_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign position  = r_pos;
    assign moving    = (r_state == ST_MOVING);
    assign door_open = (r_state == ST_DOOR);
    assign dir_up    = r_dir_up;
    assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_elevator_scheduler
// Description : Directed vector bench for elevator_scheduler (TRAVEL=4, DOOR=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] call;
    logic [1:0] position;
    logic       moving, dir_up, door_open;
    logic [3:0] pending;

    int n_vec = 0;
    int n_err = 0;

    elevator_scheduler #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .call      (call),
        .position  (position),
        .moving    (moving),
        .dir_up    (dir_up),
        .door_open (door_open),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each row: drive {rst, call} for n edges, then compare after the last one.
    typedef struct {
        logic       rst;
        logic [3:0] call;
        int         n;
        logic [1:0] pos;
        logic       mv;
        logic       up;
        logic       door;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic [3:0] c, input int n,
                                input logic [1:0] p, input logic m, input logic u,
                                input logic d, input logic [3:0] pe);
        vec_t v;
        v.rst = r; v.call = c; v.n = n;
        v.pos = p; v.mv = m; v.up = u; v.door = d; v.pend = pe;
        tbl.push_back(v);
    endfunction

    task automatic apply(input logic r, input logic [3:0] c, input int n);
        rst  = r;
        call = c;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] p, input logic m,
                         input logic u, input logic d, input logic [3:0] pe);
        n_vec++;
        if ({position, moving, dir_up, door_open, pending} !== {p, m, u, d, pe}) begin
            n_err++;
            $display("FAIL %s: got pos=%0d mv=%b up=%b door=%b pend=%b, want pos=%0d mv=%b up=%b door=%b pend=%b",
                     name, position, moving, dir_up, door_open, pending, p, m, u, d, pe);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        call = 4'b0000;

        // Single call to floor 2 from reset
        add(1, 4'b0000, 1, 2'd0, 0, 1, 0, 4'b0000);
        add(0, 4'b0100, 1, 2'd0, 1, 1, 0, 4'b0100);
        add(0, 4'b0000, 3, 2'd0, 1, 1, 0, 4'b0100);
        add(0, 4'b0000, 1, 2'd1, 1, 1, 0, 4'b0100);
        add(0, 4'b0000, 3, 2'd1, 1, 1, 0, 4'b0100);
        add(0, 4'b0000, 1, 2'd2, 0, 1, 1, 4'b0000);
        add(0, 4'b0000, 2, 2'd2, 0, 1, 1, 4'b0000);
        add(0, 4'b0000, 1, 2'd2, 0, 1, 0, 4'b0000);
        // Call at the current floor opens the door on the same edge
        add(1, 4'b0000, 1, 2'd0, 0, 1, 0, 4'b0000);
        add(0, 4'b0001, 1, 2'd0, 0, 1, 1, 4'b0000);
        add(0, 4'b0000, 2, 2'd0, 0, 1, 1, 4'b0000);
        add(0, 4'b0000, 1, 2'd0, 0, 1, 0, 4'b0000);
        // Reset mid-move with pending 1001, and reset overriding calls
        add(1, 4'b0000, 1, 2'd0, 0, 1, 0, 4'b0000);
        add(0, 4'b1000, 1, 2'd0, 1, 1, 0, 4'b1000);
        add(0, 4'b0000, 3, 2'd0, 1, 1, 0, 4'b1000);
        add(0, 4'b0000, 4, 2'd1, 1, 1, 0, 4'b1000);
        add(0, 4'b0000, 1, 2'd2, 1, 1, 0, 4'b1000);
        add(0, 4'b0001, 1, 2'd2, 1, 1, 0, 4'b1001);
        add(1, 4'b0000, 1, 2'd0, 0, 1, 0, 4'b0000);
        add(1, 4'b1111, 1, 2'd0, 0, 1, 0, 4'b0000);
        add(0, 4'b0000, 1, 2'd0, 0, 1, 0, 4'b0000);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].call, tbl[i].n);
            check($sformatf("vec%0d", i), tbl[i].pos, tbl[i].mv, tbl[i].up, tbl[i].door, tbl[i].pend);
        end

        // Call behind the car is latched and served after reversal at the top
        apply(1, 4'b0000, 1); check("rev_reset", 2'd0, 0, 1, 0, 4'b0000);
        apply(0, 4'b1000, 1); check("rev_start", 2'd0, 1, 1, 0, 4'b1000);
        apply(0, 4'b0000, 4); check("rev_at1",   2'd1, 1, 1, 0, 4'b1000);
        apply(0, 4'b0010, 1); check("rev_latch", 2'd1, 1, 1, 0, 4'b1010);
        apply(0, 4'b0000, 3); check("rev_at2",   2'd2, 1, 1, 0, 4'b1010);
        apply(0, 4'b0000, 4); check("rev_door3", 2'd3, 0, 1, 1, 4'b0010);
        apply(0, 4'b0000, 3); check("rev_leave", 2'd3, 1, 0, 0, 4'b0010);
        apply(0, 4'b0000, 4); check("rev_at2dn", 2'd2, 1, 0, 0, 4'b0010);
        apply(0, 4'b0000, 4); check("rev_door1", 2'd1, 0, 0, 1, 4'b0000);
        apply(0, 4'b0000, 3); check("rev_idle",  2'd1, 0, 0, 0, 4'b0000);

        // Door held open by a call at the same floor for five edges
        apply(1, 4'b0000, 1); check("hold_reset", 2'd0, 0, 1, 0, 4'b0000);
        apply(0, 4'b0100, 1);
        apply(0, 4'b0000, 7); check("hold_pre",   2'd1, 1, 1, 0, 4'b0100);
        apply(0, 4'b0000, 1); check("hold_open",  2'd2, 0, 1, 1, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            apply(0, 4'b0100, 1);
            check($sformatf("hold_call%0d", i), 2'd2, 0, 1, 1, 4'b0000);
        end
        for (int i = 0; i < 2; i++) begin
            apply(0, 4'b0000, 1);
            check($sformatf("hold_tail%0d", i), 2'd2, 0, 1, 1, 4'b0000);
        end
        apply(0, 4'b0000, 1); check("hold_close", 2'd2, 0, 1, 0, 4'b0000);

        // All floors called at once: served 0,1,2,3 in order
        apply(1, 4'b0000, 1); check("all_reset", 2'd0, 0, 1, 0, 4'b0000);
        apply(0, 4'b1111, 1); check("all_door0", 2'd0, 0, 1, 1, 4'b1110);
        apply(0, 4'b0000, 6); check("all_mv0",   2'd0, 1, 1, 0, 4'b1110);
        apply(0, 4'b0000, 1); check("all_door1", 2'd1, 0, 1, 1, 4'b1100);
        apply(0, 4'b0000, 6); check("all_mv1",   2'd1, 1, 1, 0, 4'b1100);
        apply(0, 4'b0000, 1); check("all_door2", 2'd2, 0, 1, 1, 4'b1000);
        apply(0, 4'b0000, 6); check("all_mv2",   2'd2, 1, 1, 0, 4'b1000);
        apply(0, 4'b0000, 1); check("all_door3", 2'd3, 0, 1, 1, 4'b0000);
        apply(0, 4'b0000, 3); check("all_idle",  2'd3, 0, 1, 0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 4, clock cycles per one-floor move; legal range 1..256.
REQ-002 Parameter DOOR_CYCLES, default 3, clock cycles the door stays open; legal range 1..256.
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port call  input  4  floor call buttons, bit i = floor i; level sampled every cycle.
REQ-006 Port position  output  2  current car floor, 0..3.
REQ-007 Port moving  output  1  high while state is MOVING.
REQ-008 Port dir_up  output  1  current travel direction, 1 = up, 0 = down.
REQ-009 Port door_open  output  1  high while state is DOOR.
REQ-010 Port pending  output  4  latched unserved calls, bit i = floor i.

Function
REQ-011 Internal: state in {IDLE, MOVING, DOOR}; travel counter and door counter, 8 bits each; req = pending | call (combinational).
REQ-012 Each edge, pending[i] sets when call[i]=1, except bit i is cleared (or stays clear) whenever the same edge enters or remains in DOOR at floor i; clear wins over set.
REQ-013 "above" = any req bit at floor > position; "below" = any req bit at floor < position.
REQ-014 IDLE, req[position]=1: go DOOR, load door counter DOOR_CYCLES-1, position and dir_up unchanged.
REQ-015 IDLE, req[position]=0, req nonzero: direction = keep dir_up if requests exist that way, else reverse; go MOVING, load travel counter TRAVEL_CYCLES-1.
REQ-016 IDLE, req zero: stay IDLE, all outputs hold.
REQ-017 MOVING, travel counter nonzero: decrement; position unchanged.
REQ-018 MOVING, travel counter zero: position steps one floor in dir_up on this edge; evaluation of next state uses the new floor f.
REQ-019 After step: req[f]=1 -> DOOR (load DOOR_CYCLES-1); else requests ahead -> MOVING same direction (reload TRAVEL_CYCLES-1); else requests behind -> flip dir_up, MOVING (reload); else IDLE.
REQ-020 DOOR: call[position]=1 reloads door counter DOOR_CYCLES-1 (door held open); otherwise decrement while nonzero.
REQ-021 DOOR, counter zero and no call at position: requests ahead -> MOVING same direction; else behind -> flip dir_up, MOVING; else IDLE; travel counter loaded TRAVEL_CYCLES-1.
REQ-022 position never leaves 0..3: at floor 3 "ahead" while up is empty by construction, same at floor 0 down; no wrap-around permitted.
REQ-023 Calls arriving during MOVING for floors already passed are latched and served after reversal.
REQ-024 Simultaneous calls on several floors: all latched the same edge; service order strictly by REQ-015/019/021 (SCAN).
REQ-025 Per-floor move latency exactly TRAVEL_CYCLES edges; door open exactly DOOR_CYCLES cycles absent re-calls.

Reset
REQ-026 rst=1 at an edge: state IDLE, position 0, dir_up 1, pending 0, counters 0, moving 0, door_open 0; rst overrides call and any state, including mid-move or door open.
REQ-027 First edge with rst=0 evaluates normally from reset state.

Verification
REQ-028 Reset, call=0100 one cycle at edge k -> moving=1 from k; position 1 at k+4, 2 at k+8; door_open=1 k+8..k+10; IDLE, pending=0 at k+11.
REQ-029 Car IDLE at 0, call=0001 one cycle -> DOOR same edge, door_open 3 cycles, position stays 0, pending stays 0.
REQ-030 Car moving up from 0 toward 3, call[1] pulse while between 1 and 2 plus call[3] -> serves 3 first, then reverses, serves 1; dir_up=0 after leaving 3.
REQ-031 Door open at floor 2, call[2] held 5 cycles -> door_open stays high for 5+DOOR_CYCLES-1 cycles total after hold start, pending[2]=0 throughout.
REQ-032 rst asserted mid-move at position 2 with pending=1001 -> next edge position 0, pending 0, IDLE, dir_up 1.
REQ-033 All four calls pulsed at once from reset -> door at 0, then 1, 2, 3 in order, each separated by TRAVEL_CYCLES+DOOR_CYCLES edges; ends IDLE at 3.
